// File: rtl/inst_rom.sv
// Fetch-side instruction memory with a streaming load port.
// Fetches are served only after a complete program load.
module inst_rom #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  loaded
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_W = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE_W  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  we;
    logic                  beat;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // ld_start outranks a coincident beat and a coincident fetch
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        we      = 1'b0;
        inst_d  = '0;
        valid_d = 1'b0;
        beat    = ld_valid && (state_q == LOAD) && !ld_start;

        if (ld_start) begin
            state_d = LOAD;
            wptr_d  = '0;
        end else if (beat) begin
            we     = 1'b1;
            wptr_d = wptr_q + ONE_W;
            if (ld_last || (wptr_q == LAST_W)) begin
                state_d = RUN;
            end
        end

        if ((state_q == RUN) && ce && !ld_start) begin
            inst_d  = mem_q[pc];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= ld_data;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign ld_ready   = (state_q == LOAD);
    assign loaded     = (state_q == RUN);

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: stimulus queues expected
// post-edge outputs, a monitor pops and checks each cycle.
module tb_inst_rom;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [5:0]  pc = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        loaded;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          id;
        logic        v;
        logic [31:0] d;
        logic        ld;
        logic        rd;
    } exp_t;

    exp_t sb[$];
    int   step_id = 0;

    inst_rom #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .pc(pc),
        .inst(inst),
        .inst_valid(inst_valid),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_last(ld_last),
        .ld_ready(ld_ready),
        .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id,
                       input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: output after each edge against the queued expectation
    always @(posedge clk) begin
        #1;
        if (!rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("fetch", e.id, {3'b0, inst_valid, inst}, {3'b0, e.v, e.d});
            chk("status", e.id, {34'b0, loaded, ld_ready}, {34'b0, e.ld, e.rd});
        end
    end

    task automatic step(input logic c, input logic [5:0] p,
                        input logic st, input logic lv,
                        input logic [31:0] dat, input logic lst,
                        input logic ev, input logic [31:0] ed,
                        input logic eld, input logic erd);
        exp_t e;
        @(negedge clk);
        ce       = c;
        pc       = p;
        ld_start = st;
        ld_valid = lv;
        ld_data  = dat;
        ld_last  = lst;
        e.id = step_id;
        e.v  = ev;
        e.d  = ed;
        e.ld = eld;
        e.rd = erd;
        sb.push_back(e);
        step_id++;
    endtask

    task automatic fetch(input logic [5:0] p, input logic [31:0] ed);
        step(1, p, 0, 0, 0, 0, 1, ed, 1, 0);
    endtask

    initial begin
        int budget;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", -1, {2'b0, ld_ready, loaded, inst_valid, inst}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch with no program loaded
        repeat (3) step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);

        // Four-word load ending on ld_last
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 32'h1111_1111 * (i + 1), (i == 3),
                 0, 0, (i == 3), (i != 3));
        end
        for (int i = 0; i < 4; i++) begin
            fetch(6'(i), 32'h1111_1111 * (i + 1));
        end

        // ld_valid held high in RUN must not write
        step(1, 0, 0, 1, 32'h0BAD_0BAD, 0, 1, 32'h1111_1111, 1, 0);
        step(1, 1, 0, 1, 32'h0BAD_0BAD, 1, 1, 32'h2222_2222, 1, 0);
        // ce toggling 1,0,1
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        fetch(0, 32'h1111_1111);
        fetch(1, 32'h2222_2222);

        // Reload in RUN while fetching: fetch dropped
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        // Full 64-word load with ld_last low throughout
        for (int i = 0; i < 64; i++) begin
            step(0, 0, 0, 1, 32'hA000_0000 + i, 0,
                 0, 0, (i == 63), (i != 63));
        end
        fetch(62, 32'hA000_003E);
        fetch(63, 32'hA000_003F);
        fetch(0, 32'hA000_0000);
        fetch(4, 32'hA000_0004);

        // ld_start colliding with a beat
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 32'h0000_0001, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 32'h6666_6666, 1, 0, 0, 1, 0);
        fetch(0, 32'h5555_5555);
        fetch(1, 32'h6666_6666);
        fetch(2, 32'hA000_0002);

        // Reset after two of four beats
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 32'h7777_7777, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 32'h8888_8888, 0, 0, 0, 0, 1);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_start = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst", -2, {2'b0, ld_ready, loaded, inst_valid, inst}, '0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 32'hC000_0000 + i, (i == 3),
                 0, 0, (i == 3), (i != 3));
        end
        for (int i = 0; i < 4; i++) begin
            fetch(6'(i), 32'hC000_0000 + i);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
